// File: rtl/fxp_to_half_enc.sv
// ---------------------------------------------------------------------------
// fxp_to_half_enc
//
// Converts a sign / 16-bit integer / 32-bit fraction fixed-point operand into
// IEEE-754 half precision (1/5/10, bias 15). The leading one is found by
// shifting one bit per cycle. Mantissa bits below the 10 kept are truncated,
// which rounds toward zero. Results too small for a normal half are flushed
// to a signed zero and flagged. Feeds the a/b operands of the fpa adder.
//
// Handshake contract (both sides):
//   - A transfer happens on a rising clk edge where valid && ready are high.
//   - in_ready is high only while the encoder is idle. Inputs are sampled
//     only on the accept edge; in_valid is ignored at all other times.
//   - out_valid, once raised, stays high with out_half/out_zero/out_uflow
//     stable until out_ready is seen. out_ready has no effect while
//     out_valid is low.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input operand valid
//   in_ready   encoder can accept an operand (idle)
//   in_sign    operand sign, 1 = negative
//   in_int     unsigned integer part
//   in_frac    binary fraction, bit 31 = 2^-1 ... bit 0 = 2^-32
//   out_valid  result valid, held until accepted
//   out_ready  downstream accepts the result
//   out_half   half-precision result
//   out_zero   input magnitude was exactly zero
//   out_uflow  nonzero input below 2^-14, flushed to signed zero
// ---------------------------------------------------------------------------
module fxp_to_half_enc (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [15:0] in_int,
  input  logic [31:0] in_frac,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_half,
  output logic        out_zero,
  output logic        out_uflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_PACK = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // After 29 shifts without a leading one in bit 47 the original leading
  // one sat at or below bit 17 (2^-15), i.e. the biased exponent is <= 0.
  localparam logic [4:0] S_LAST = 5'd29;

  logic [1:0]  state;
  logic [47:0] m;        // {int, frac}: bit 47 = 2^15, bit 32 = 2^0
  logic [4:0]  s;        // left shifts applied so far
  logic        sign_q;
  logic        zero_q;
  logic        uflow_q;

  logic [47:0] in_mag;
  assign in_mag   = {in_int, in_frac};
  assign in_ready = (state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      m         <= '0;
      s         <= '0;
      sign_q    <= 1'b0;
      zero_q    <= 1'b0;
      uflow_q   <= 1'b0;
      out_valid <= 1'b0;
      out_half  <= '0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            m       <= in_mag;
            sign_q  <= in_sign;
            s       <= '0;
            uflow_q <= 1'b0;
            zero_q  <= (in_mag == '0);
            // A zero magnitude has no leading one; skip the search.
            state   <= (in_mag == '0) ? ST_PACK : ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (m[47]) begin
            state <= ST_PACK;
          end else if (s == S_LAST) begin
            uflow_q <= 1'b1;
            state   <= ST_PACK;
          end else begin
            m <= m << 1;
            s <= s + 5'd1;
          end
        end

        ST_PACK: begin
          out_valid <= 1'b1;
          out_zero  <= zero_q;
          out_uflow <= uflow_q;
          if (zero_q || uflow_q) begin
            out_half <= {sign_q, 15'b0};
          end else begin
            // Leading one now at bit 47 (2^15): unbiased exp = 15 - s,
            // biased = 30 - s, always in 1..30. Bit 47 is the hidden one.
            out_half <= {sign_q, 5'(5'd30 - s), m[46:37]};
          end
          state <= ST_HOLD;
        end

        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_to_half_enc.sv
// ---------------------------------------------------------------------------
// tb_fxp_to_half_enc
//
// Table of hand-derived vectors, hand-written backpressure and reset
// sequences, and randomized operands checked against an arithmetic model
// (leading-one position -> exponent, magnitude scaled down -> mantissa).
// ---------------------------------------------------------------------------
module tb_fxp_to_half_enc;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [15:0] in_int;
  logic [31:0] in_frac;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_half;
  logic        out_zero;
  logic        out_uflow;

  always #5 clk = ~clk;

  fxp_to_half_enc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_int    (in_int),
    .in_frac   (in_frac),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_half  (out_half),
    .out_zero  (out_zero),
    .out_uflow (out_uflow)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic        sign;
    logic [15:0] ii;
    logic [31:0] ff;
    logic [15:0] h;
    logic        z;
    logic        u;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: value = mag * 2^-32. Leading one at bit p means value in
  // [2^(p-32), 2^(p-31)), so biased exponent = p - 32 + 15. The 10 mantissa
  // bits are the magnitude divided down to 11 bits, hidden one dropped.
  // The search needs 47-p shifts plus one pack cycle plus the register.
  task automatic model(input logic sg, input logic [47:0] mag,
                       output logic [15:0] h, output logic z, output logic u,
                       output int lat);
    int p;
    logic [47:0] t;
    p = -1;
    for (int i = 0; i < 48; i++) if (mag[i]) p = i;
    z = 1'b0;
    u = 1'b0;
    if (p < 0) begin
      h = {sg, 15'b0}; z = 1'b1; lat = 1;
    end else if (p - 17 <= 0) begin
      h = {sg, 15'b0}; u = 1'b1; lat = 31;
    end else begin
      t   = mag >> (p - 10);
      h   = {sg, 5'(p - 17), t[9:0]};
      lat = 49 - p;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input string name, input logic sg, input logic [15:0] ii,
                        input logic [31:0] ff, input logic [15:0] eh,
                        input logic ez, input logic eu, input int el);
    int lat;
    int w;
    logic [15:0] exp_h;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check({name, " in_ready_before"}, 32'(in_ready), 32'd1);
    in_sign  = sg;
    in_int   = ii;
    in_frac  = ff;
    in_valid = 1'b1;
    exp_q.push_back(eh);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs: only the accept-edge sample may matter.
    in_sign  = 1'($urandom);
    in_int   = 16'($urandom);
    in_frac  = $urandom;
    check({name, " in_ready_after_accept"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    exp_h = exp_q.pop_front();
    check({name, " latency"}, 32'(lat), 32'(el));
    check({name, " half"}, 32'(out_half), 32'(exp_h));
    check({name, " zero"}, 32'(out_zero), 32'(ez));
    check({name, " uflow"}, 32'(out_uflow), 32'(eu));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " valid_dropped"}, 32'(out_valid), 32'd0);
    check({name, " in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [15:0] h;
    logic        z;
    logic        u;
    int          lat;
    logic [47:0] mag;
    logic        sg;
    logic [15:0] held;
    int          pulses;

    vecs[0] = '{1'b0, 16'h0001, 32'h9999999A, 16'h3E66, 1'b0, 1'b0, 17};
    vecs[1] = '{1'b0, 16'h0000, 32'h80000000, 16'h3800, 1'b0, 1'b0, 18};
    vecs[2] = '{1'b0, 16'hFFFF, 32'hFFFFFFFF, 16'h7BFF, 1'b0, 1'b0, 2};
    vecs[3] = '{1'b1, 16'h0000, 32'h00000000, 16'h8000, 1'b1, 1'b0, 1};
    vecs[4] = '{1'b0, 16'h0000, 32'h00020000, 16'h0000, 1'b0, 1'b1, 31};
    vecs[5] = '{1'b0, 16'h0000, 32'h00040000, 16'h0400, 1'b0, 1'b0, 31};
    vecs[6] = '{1'b0, 16'h0001, 32'h73333333, 16'h3DCC, 1'b0, 1'b0, 17};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_int    = '0;
    in_frac   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_half", 32'(out_half), 32'd0);
    check("reset flags", {30'd0, out_zero, out_uflow}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors
    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].sign, vecs[i].ii, vecs[i].ff,
             vecs[i].h, vecs[i].z, vecs[i].u, vecs[i].lat);

    // Backpressure: result held, in_ready low, new in_valid ignored.
    in_sign = 1'b0; in_int = 16'h0001; in_frac = 32'h9999999A; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    check("bp latency", 32'(lat), 32'd17);
    held = 16'h3E66;
    in_sign = 1'b1; in_int = 16'h1234; in_frac = 32'h0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp half_stable", 32'(out_half), 32'(held));
      check("bp in_ready_low", 32'(in_ready), 32'd0);
      check("bp valid_held", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp in_ready_back", 32'(in_ready), 32'd1);
    check("bp valid_dropped", 32'(out_valid), 32'd0);
    // The operand offered during HOLD must not have been captured.
    repeat (3) @(posedge clk);
    #1;
    check("bp no_ghost_result", 32'(out_valid), 32'd0);
    run_op("after_bp 0.5", 1'b0, 16'h0000, 32'h80000000, 16'h3800, 1'b0, 1'b0, 18);

    // Reset mid-SCAN of 1.45
    in_sign = 1'b0; in_int = 16'h0001; in_frac = 32'h73333333; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("scan_rst in_ready", 32'(in_ready), 32'd1);
    check("scan_rst out_valid", 32'(out_valid), 32'd0);
    check("scan_rst out_half", 32'(out_half), 32'd0);
    check("scan_rst flags", {30'd0, out_zero, out_uflow}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("scan_rst no_pulse", 32'(pulses), 32'd0);
    run_op("after_rst 1.6", 1'b0, 16'h0001, 32'h9999999A, 16'h3E66, 1'b0, 1'b0, 17);

    // Reset while in HOLD
    in_sign = 1'b1; in_int = 16'hFFFF; in_frac = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_rst valid_before", 32'(out_valid), 32'd1);
    check("hold_rst half_before", 32'(out_half), 32'hFBFF);
    rst = 1'b1;
    #1;
    check("hold_rst out_valid", 32'(out_valid), 32'd0);
    check("hold_rst out_half", 32'(out_half), 32'd0);
    check("hold_rst in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Randomized operands against the model
    for (int i = 0; i < 40; i++) begin
      mag = {16'($urandom), $urandom} >> $urandom_range(0, 47);
      if ($urandom_range(0, 9) == 0) mag = '0;
      sg = 1'($urandom);
      model(sg, mag, h, z, u, lat);
      run_op($sformatf("rand%0d", i), sg, mag[47:32], mag[31:0], h, z, u, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
